// File: rtl/lsl8_seq_ctrl_if.sv
// Request/response bundle between a requester and the LSL8 shift sequencer.
// The requester drives the command fields and the sequencer returns status and result.
interface lsl8_seq_ctrl_if;
    logic       start;
    logic [7:0] d_in;
    logic [3:0] amt;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] d_out;
    logic [2:0] step_cnt;

    modport master (
        output start, d_in, amt,
        input  ready, busy, done, d_out, step_cnt
    );

    modport slave (
        input  start, d_in, amt,
        output ready, busy, done, d_out, step_cnt
    );
endinterface

// File: rtl/lsl8_seq_ctrl.sv
// Sequencer that realises an 8-bit logical left shift of 0..15 by applying a
// 2-bit-shamt LSL8 stage repeatedly, at most 3 positions per clock.
module lsl8_seq_ctrl (
    input  logic           clk,
    input  logic           reset,
    lsl8_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] rem_q, rem_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] d_out_q, d_out_d;
    logic [2:0] step_cnt_q, step_cnt_d;

    logic [1:0] shamt;
    logic [7:0] shifted;
    logic [3:0] rem_next;

    // The combinational LSL8 datapath: bits past bit 7 drop, zeros enter at bit 0.
    function automatic logic [7:0] lsl8(input logic [7:0] a, input logic [1:0] s);
        logic [7:0] r;
        r = a << s;
        return r;
    endfunction

    always_comb begin
        shamt    = (rem_q > 4'd3) ? 2'd3 : rem_q[1:0];
        shifted  = lsl8(acc_q, shamt);
        rem_next = rem_q - {2'b00, shamt};
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        d_out_d    = d_out_q;
        step_cnt_d = step_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = 3'd0;
                    // Shifts of 8 or more clear everything, so a single zero pass suffices.
                    if (bus.amt < 4'd8) begin
                        acc_d = bus.d_in;
                        rem_d = bus.amt;
                    end else begin
                        acc_d = 8'h00;
                        rem_d = 4'd0;
                    end
                end
            end
            SHIFT: begin
                acc_d = shifted;
                rem_d = rem_next;
                cnt_d = cnt_q + 3'd1;
                if (rem_next == 4'd0) begin
                    state_d    = DONE;
                    d_out_d    = shifted;
                    step_cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= 8'h00;
            rem_q      <= 4'd0;
            cnt_q      <= 3'd0;
            d_out_q    <= 8'h00;
            step_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            d_out_q    <= d_out_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.busy     = (state_q == SHIFT) || (state_q == DONE);
    assign bus.done     = (state_q == DONE);
    assign bus.d_out    = d_out_q;
    assign bus.step_cnt = step_cnt_q;

    // DONE always falls straight back to IDLE, so the pulse can never stretch.
    a_done_single: assert property (@(posedge clk) disable iff (reset) bus.done |=> !bus.done);

endmodule

// File: tb/tb_lsl8_seq_ctrl.sv
// Directed bench for lsl8_seq_ctrl: hand-computed shift results, pass counts and handshake timing.
module tb_lsl8_seq_ctrl;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    lsl8_seq_ctrl_if bus ();

    lsl8_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and lets the accepting edge pass; start drops afterwards.
    task automatic issue(input logic [7:0] d, input logic [3:0] a);
        bus.start = 1'b1;
        bus.d_in  = d;
        bus.amt   = a;
        tick();
        bus.start = 1'b0;
        bus.d_in  = 8'h00;
        bus.amt   = 4'd0;
    endtask

    // Counts edges after acceptance until done is seen; -1 if it never arrives.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.d_in  = 8'h00;
        bus.amt   = 4'd0;
        tick();
        tick();
        tests++;
        if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
            fails++;
            $display("FAIL reset_flags got=%b want=100", {bus.ready, bus.busy, bus.done});
        end
        tests++;
        if (bus.d_out !== 8'h00 || bus.step_cnt !== 3'd0) begin
            fails++;
            $display("FAIL reset_data got d_out=%h step=%0d want 00/0", bus.d_out, bus.step_cnt);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got ready=%b busy=%b want 1/0", bus.ready, bus.busy);
        end
    endtask

    task automatic test_amt0();
        int cyc;
        issue(8'hAD, 4'd0);
        tests++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            fails++;
            $display("FAIL amt0_busy got busy=%b ready=%b want 1/0", bus.busy, bus.ready);
        end
        wait_done(cyc);
        tests++;
        if (cyc !== 1) begin
            fails++;
            $display("FAIL amt0_latency got=%0d want=1", cyc);
        end
        tests++;
        if (bus.d_out !== 8'hAD || bus.step_cnt !== 3'd1) begin
            fails++;
            $display("FAIL amt0_result got %h/%0d want AD/1", bus.d_out, bus.step_cnt);
        end
        tick();
        tests++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL amt0_return got ready=%b done=%b want 1/0", bus.ready, bus.done);
        end
    endtask

    task automatic test_amt5();
        issue(8'hAD, 4'd5);
        tick();
        tests++;
        if (dut.acc_q !== 8'h68 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL amt5_acc1 got acc=%h done=%b want 68/0", dut.acc_q, bus.done);
        end
        tick();
        tests++;
        if (dut.acc_q !== 8'hA0 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL amt5_acc2 got acc=%h done=%b want A0/1", dut.acc_q, bus.done);
        end
        tests++;
        if (bus.d_out !== 8'hA0 || bus.step_cnt !== 3'd2) begin
            fails++;
            $display("FAIL amt5_result got %h/%0d want A0/2", bus.d_out, bus.step_cnt);
        end
        tick();
    endtask

    task automatic test_amt7();
        logic [7:0] exp_acc [3];
        int busy_cyc;
        exp_acc[0] = 8'h68;
        exp_acc[1] = 8'h40;
        exp_acc[2] = 8'h80;
        issue(8'hAD, 4'd7);
        busy_cyc = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (dut.acc_q !== exp_acc[i]) begin
                fails++;
                $display("FAIL amt7_acc%0d got=%h want=%h", i, dut.acc_q, exp_acc[i]);
            end
            if (bus.busy === 1'b1) busy_cyc++;
        end
        tests++;
        if (bus.done !== 1'b1 || bus.d_out !== 8'h80 || bus.step_cnt !== 3'd3) begin
            fails++;
            $display("FAIL amt7_result got done=%b %h/%0d want 1 80/3", bus.done, bus.d_out, bus.step_cnt);
        end
        tick();
        if (bus.busy === 1'b1) busy_cyc++;
        tests++;
        if (busy_cyc !== 4) begin
            fails++;
            $display("FAIL amt7_busy_len got=%0d want=4", busy_cyc);
        end
    endtask

    task automatic test_amt_ge8();
        int cyc;
        logic [3:0] amts [2];
        amts[0] = 4'd9;
        amts[1] = 4'd8;
        for (int k = 0; k < 2; k++) begin
            issue(8'hFF, amts[k]);
            wait_done(cyc);
            tests++;
            if (cyc !== 1 || bus.d_out !== 8'h00 || bus.step_cnt !== 3'd1) begin
                fails++;
                $display("FAIL ge8_amt%0d got cyc=%0d %h/%0d want 1 00/1", amts[k], cyc, bus.d_out, bus.step_cnt);
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [7:0] last_out;
        issue(8'hAD, 4'd7);
        bus.start = 1'b1;
        bus.d_in  = 8'h01;
        bus.amt   = 4'd3;
        tick();
        bus.start = 1'b0;
        dones    = 0;
        last_out = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                last_out = bus.d_out;
            end
            tick();
        end
        tests++;
        if (dones !== 1 || last_out !== 8'h80) begin
            fails++;
            $display("FAIL ignore_start got dones=%0d d_out=%h want 1/80", dones, last_out);
        end
        tests++;
        if (bus.ready !== 1'b1 || bus.d_out !== 8'h80) begin
            fails++;
            $display("FAIL ignore_idle got ready=%b d_out=%h want 1/80", bus.ready, bus.d_out);
        end
    endtask

    task automatic test_back_to_back();
        int done_at [$];
        bus.start = 1'b1;
        bus.d_in  = 8'hAD;
        bus.amt   = 4'd5;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                done_at.push_back(i);
                tests++;
                if (bus.ready !== 1'b0 || bus.d_out !== 8'hA0) begin
                    fails++;
                    $display("FAIL b2b_done%0d got ready=%b d_out=%h want 0/A0", i, bus.ready, bus.d_out);
                end
            end
        end
        bus.start = 1'b0;
        tests++;
        if (done_at.size() !== 4) begin
            fails++;
            $display("FAIL b2b_count got=%0d want=4", done_at.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (done_at[k] !== 2 + 4 * k) begin
                    fails++;
                    $display("FAIL b2b_time%0d got=%0d want=%0d", k, done_at[k], 2 + 4 * k);
                end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        int cyc;
        issue(8'hAD, 4'd7);
        tick();
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.ready, bus.busy, bus.done} !== 3'b100 || bus.d_out !== 8'h00 || bus.step_cnt !== 3'd0) begin
            fails++;
            $display("FAIL async_reset got rbd=%b %h/%0d want 100 00/0",
                     {bus.ready, bus.busy, bus.done}, bus.d_out, bus.step_cnt);
        end
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL async_hold got done=%b ready=%b want 0/1", bus.done, bus.ready);
        end
        reset = 1'b0;
        tick();
        issue(8'hAD, 4'd2);
        wait_done(cyc);
        tests++;
        if (cyc !== 1 || bus.d_out !== 8'hB4 || bus.step_cnt !== 3'd1) begin
            fails++;
            $display("FAIL after_reset got cyc=%0d %h/%0d want 1 B4/1", cyc, bus.d_out, bus.step_cnt);
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_amt0();
        test_amt5();
        test_amt7();
        test_amt_ge8();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsl8_seq_ctrl.md
# lsl8_seq_ctrl

Multi-cycle sequencer that drives an internal 2-bit-shamt `LSL8` logical-left shifter to perform 8-bit logical shifts of 0..15 positions. It accepts one request at a time through a start/ready handshake. It then applies the shifter repeatedly, up to 3 positions per clock, until the requested amount is consumed, and reports the result with a one-cycle `done` pulse. It sits between a requester, such as a small ALU or a test harness, and the combinational `LSL8` datapath.

## Interface
Parameters:
- none; the width is fixed at 8 bits and the per-step maximum at 3, matching `LSL8`.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `start`  in  1  request strobe; sampled only while `ready`=1.
- `d_in`  in  8  operand, captured on the accepting edge.
- `amt`  in  4  total shift amount 0..15, captured on the accepting edge.
- `ready`  out  1  high only in IDLE (decoded from state).
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse, high only in DONE.
- `d_out`  out  8  registered result; holds its value until the next completion or reset.
- `step_cnt`  out  3  number of shifter passes used by the last completed op, range 1..3.

## Operation
- States:
  - IDLE(00), SHIFT(01), DONE(10). Code 11 is illegal and returns to IDLE on the next edge.
- Internal registers:
  - `acc[7:0]`, `rem[3:0]`, `cnt[2:0]`.
- IDLE:
  - If `start`=1, the edge loads `cnt`<=0 and goes to SHIFT.
  - If `amt`<8, the same edge loads `acc`<=`d_in` and `rem`<=`amt`.
  - If `amt`>=8, it loads `acc`<=0 and `rem`<=0; the result is 0 and exactly one pass is made.
- SHIFT, each edge:
  - `shamt` = (`rem`>3) ? 3 : `rem[1:0]`.
  - `acc`<=LSL8(`acc`, `shamt`), `rem`<=`rem`-`shamt`, `cnt`<=`cnt`+1.
  - When `rem`-`shamt`==0, go to DONE, and load `d_out`<=LSL8(`acc`,`shamt`) and `step_cnt`<=`cnt`+1 on that edge.
- DONE: the next edge unconditionally returns to IDLE.
- `amt`=0 still makes one pass with `shamt`=0, so `d_out`=`d_in` and `step_cnt`=1.
- `start` is ignored whenever `ready`=0; there is no queueing. `d_in` and `amt` are don't-care outside the accepting edge.
- Bits shifted past bit 7 are discarded, and 0 fills from the LSB. The result equals (`d_in` << `amt`) truncated to 8 bits.

## Timing
- Passes: N = max(1, ceil(`amt`/3)) for `amt`<8, and N = 1 for `amt`>=8.
- Start accepted on edge E0. SHIFT occupies edges E1..EN. `done`=1 and the new `d_out` are valid in the cycle after EN. `ready` rises one edge later.
- Request-to-request throughput: N+2 cycles.
- Reset values:
  - state IDLE, `ready`=1, `busy`=0, `done`=0.
  - `d_out`=0x00, `step_cnt`=0, `acc`=0, `rem`=0, `cnt`=0.
- Reset asserted mid-op:
  - Enter IDLE immediately; the op is abandoned with no `done` pulse.
  - `d_out` and `step_cnt` clear to 0.
- `start` held high through DONE: not accepted until the first IDLE edge, so a new op starts E0 one cycle after `done` falls.
- `done` is never high for two consecutive cycles.

## Test plan
- `d_in`=0xAD, `amt`=0:
  - `done` one cycle after the accepting edge.
  - `d_out`=0xAD, `step_cnt`=1.
- `d_in`=0xAD, `amt`=5:
  - `acc` sequence 0x68 then 0xA0.
  - `done` 2 edges after acceptance, with `d_out`=0xA0 and `step_cnt`=2.
- `d_in`=0xAD, `amt`=7:
  - `acc` sequence 0x68, 0x40, 0x80.
  - `d_out`=0x80, `step_cnt`=3, `busy` high for 4 cycles.
- `d_in`=0xFF, `amt`=9:
  - `d_out`=0x00 and `step_cnt`=1 after one pass.
  - Repeat with `amt`=8 for the same result.
- Handshake:
  - Pulse `start` with `amt`=3 while an `amt`=7 op is in SHIFT; it is ignored, giving a single `done` with `d_out`=0x80.
  - Hold `start` high continuously; ops are accepted every N+2 cycles.
- Reset:
  - Assert `reset` asynchronously, between edges, on the second SHIFT cycle of an `amt`=7 op.
  - Outputs go to reset values without waiting for a clock edge: `ready`=1, `d_out`=0x00, `step_cnt`=0, and no `done` pulse.
  - After release, a new `amt`=2 op on 0xAD yields 0xB4.
